// File: rtl/m3_speed_ramp_gen.sv
// Commutation step sequencer for a sensorless motor drive: walks through the
// electrical steps at a programmable period, ramps the period up/down on
// request once every few electrical rounds, manages a power level and
// performs a controlled slow-down before reversing the rotation direction.
module m3_speed_ramp_gen #(
  parameter int PERIOD_W   = 22,
  parameter int PERIOD_MIN = 40,
  parameter int PERIOD_MAX = 4000000,
  parameter int STEPS      = 12,
  parameter int RATE_SHIFT = 4,
  parameter int ROUND_DIV  = 3,
  parameter int POWER_W    = 10,
  parameter int POWER_MAX  = 1000,
  parameter int POWER_INIT = 100,
  parameter int POWER_STEP = 10
) (
  input  logic                clkI,
  input  logic                rstI,
  input  logic                startI,
  input  logic                forceStopI,
  input  logic                invRotateI,
  input  logic                speedIncI,
  input  logic                speedDecI,
  input  logic                powerIncI,
  input  logic                powerDecI,
  output logic [3:0]          stepO,
  output logic                stepStbO,
  output logic                roundStbO,
  output logic [PERIOD_W-1:0] periodO,
  output logic [POWER_W-1:0]  powerO,
  output logic                dirO,
  output logic [1:0]          stateO
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REVERSE = 2'd2} stateT;
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_INC = 2'd1, REQ_DEC = 2'd2} reqT;

  localparam logic [PERIOD_W-1:0] PMAX      = PERIOD_W'(PERIOD_MAX);
  localparam logic [PERIOD_W-1:0] PMIN      = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W:0]   PMAX_X    = (PERIOD_W+1)'(PERIOD_MAX);
  localparam logic [PERIOD_W:0]   PMIN_X    = (PERIOD_W+1)'(PERIOD_MIN);
  localparam logic [3:0]          STEP_LAST = 4'(STEPS - 1);
  localparam logic [7:0]          PRE_INIT  = 8'(ROUND_DIV);
  localparam logic [POWER_W-1:0]  PWR_MAX   = POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0]  PWR_INIT  = POWER_W'(POWER_INIT);
  localparam logic [POWER_W-1:0]  PWR_STEP  = POWER_W'(POWER_STEP);
  localparam logic [POWER_W:0]    PWR_MAX_X = (POWER_W+1)'(POWER_MAX);
  localparam logic [POWER_W:0]    PWR_STP_X = (POWER_W+1)'(POWER_STEP);

  stateT               state;
  reqT                 prevReq;
  logic [PERIOD_W-1:0] remain;
  logic [7:0]          prescaler;

  logic                wrap;
  logic [3:0]          stepNext;
  logic [PERIOD_W:0]   periodX;
  logic [PERIOD_W:0]   delta;
  logic [PERIOD_W:0]   upSum;
  logic [PERIOD_W:0]   downDiff;
  logic [PERIOD_W-1:0] periodUp;
  logic [PERIOD_W-1:0] periodDown;
  logic [POWER_W:0]    powerSum;
  logic [POWER_W-1:0]  powerNext;
  reqT                 req;
  stateT               roundState;
  logic [PERIOD_W-1:0] roundPeriod;
  logic [7:0]          roundPresc;
  logic                roundDir;
  reqT                 roundPrev;

  assign stateO = state;

  // Next step / saturated period and power candidates, plus the decision
  // taken at a round boundary (ramp, reversal progress, direction flip).
  always_comb begin
    wrap        = dirO ? (stepO == 4'd0) : (stepO == STEP_LAST);
    stepNext    = dirO ? (wrap ? STEP_LAST : stepO - 4'd1)
                       : (wrap ? 4'd0 : stepO + 4'd1);
    periodX     = {1'b0, periodO};
    delta       = periodX >> RATE_SHIFT;
    if (delta == '0) delta = (PERIOD_W+1)'(1);
    upSum       = periodX + delta;
    periodUp    = (upSum > PMAX_X) ? PMAX : upSum[PERIOD_W-1:0];
    downDiff    = (periodX > delta) ? periodX - delta : '0;
    periodDown  = (downDiff < PMIN_X) ? PMIN : downDiff[PERIOD_W-1:0];

    powerSum    = {1'b0, powerO} + PWR_STP_X;
    powerNext   = powerO;
    if (powerIncI && !powerDecI)
      powerNext = (powerSum > PWR_MAX_X) ? PWR_MAX : powerSum[POWER_W-1:0];
    else if (powerDecI && !powerIncI)
      powerNext = (powerO < PWR_STEP) ? '0 : powerO - PWR_STEP;

    req         = REQ_NONE;
    if (speedIncI && !speedDecI) req = REQ_INC;
    else if (speedDecI && !speedIncI) req = REQ_DEC;

    roundState  = state;
    roundPeriod = periodO;
    roundPresc  = prescaler;
    roundDir    = dirO;
    roundPrev   = prevReq;
    case (state)
      RUN: begin
        if (invRotateI != dirO) begin
          roundState = REVERSE;
          roundPrev  = REQ_NONE;
        end else begin
          roundPrev = req;
          if (req == REQ_NONE ||
              (req == REQ_INC && prevReq == REQ_DEC) ||
              (req == REQ_DEC && prevReq == REQ_INC)) begin
            roundPresc = PRE_INIT;
          end else if (prescaler == 8'd0) begin
            roundPresc  = PRE_INIT;
            roundPeriod = (req == REQ_INC) ? periodDown : periodUp;
          end else begin
            roundPresc = prescaler - 8'd1;
          end
        end
      end
      REVERSE: begin
        roundPrev = REQ_NONE;
        if (invRotateI == dirO) begin
          roundState = RUN;
          roundPresc = PRE_INIT;
        end else if (periodO == PMAX) begin
          roundState = RUN;
          roundPresc = PRE_INIT;
          roundDir   = invRotateI;
        end else begin
          roundPeriod = periodUp;
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: stop/idle handling, per-clock step countdown and the
  // registered round-boundary updates.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      state     <= IDLE;
      stepO     <= 4'd0;
      stepStbO  <= 1'b0;
      roundStbO <= 1'b0;
      periodO   <= PMAX;
      remain    <= PMAX;
      prescaler <= PRE_INIT;
      prevReq   <= REQ_NONE;
      powerO    <= PWR_INIT;
      dirO      <= 1'b0;
    end else if (!startI || forceStopI) begin
      state     <= IDLE;
      stepO     <= 4'd0;
      stepStbO  <= 1'b0;
      roundStbO <= 1'b0;
      periodO   <= PMAX;
      remain    <= PMAX;
      prescaler <= PRE_INIT;
      prevReq   <= REQ_NONE;
      if (state == IDLE) dirO <= invRotateI;
    end else if (state == IDLE) begin
      state     <= RUN;
      dirO      <= invRotateI;
      remain    <= PMAX;
      stepStbO  <= 1'b0;
      roundStbO <= 1'b0;
    end else begin
      stepStbO  <= 1'b0;
      roundStbO <= 1'b0;
      if (remain == PERIOD_W'(1)) begin
        stepStbO <= 1'b1;
        stepO    <= stepNext;
        if (wrap) begin
          roundStbO <= 1'b1;
          state     <= roundState;
          periodO   <= roundPeriod;
          prescaler <= roundPresc;
          dirO      <= roundDir;
          prevReq   <= roundPrev;
          powerO    <= powerNext;
          remain    <= roundPeriod;
        end else begin
          remain <= periodO;
        end
      end else begin
        remain <= remain - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_m3_speed_ramp_gen.sv
// Directed bench for the speed ramp generator. Uses a short period range and
// two steps per round so full ramps complete in a modest number of clocks.
module tb_m3_speed_ramp_gen;

  localparam int PW   = 22;
  localparam int PMAX = 300;
  localparam int PMIN = 40;

  logic          clkI = 1'b0;
  logic          rstI, startI, forceStopI, invRotateI;
  logic          speedIncI, speedDecI, powerIncI, powerDecI;
  logic [3:0]    stepO;
  logic          stepStbO, roundStbO;
  logic [PW-1:0] periodO;
  logic [9:0]    powerO;
  logic          dirO;
  logic [1:0]    stateO;

  int total = 0;
  int bad   = 0;

  m3_speed_ramp_gen #(
    .PERIOD_W(PW), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .STEPS(2),
    .RATE_SHIFT(4), .ROUND_DIV(3), .POWER_W(10), .POWER_MAX(1000),
    .POWER_INIT(100), .POWER_STEP(10)
  ) dut (
    .clkI(clkI), .rstI(rstI), .startI(startI), .forceStopI(forceStopI),
    .invRotateI(invRotateI), .speedIncI(speedIncI), .speedDecI(speedDecI),
    .powerIncI(powerIncI), .powerDecI(powerDecI), .stepO(stepO),
    .stepStbO(stepStbO), .roundStbO(roundStbO), .periodO(periodO),
    .powerO(powerO), .dirO(dirO), .stateO(stateO)
  );

  // Free-running clock
  always #5 clkI = ~clkI;

  task automatic tick;
    @(posedge clkI);
    #1;
  endtask

  task automatic waitStep(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      n++;
      if (stepStbO) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic runRounds(input int count, output bit ok);
    ok = 1'b1;
    for (int r = 0; r < count; r++) begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        tick();
        if (roundStbO) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstI = 1'b1; startI = 1'b1; forceStopI = 1'b0; invRotateI = 1'b0;
    speedIncI = 1'b0; speedDecI = 1'b0; powerIncI = 1'b0; powerDecI = 1'b0;
    repeat (3) tick();
    total++; if (stateO !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got %0d want 0", stateO); end
    total++; if (stepO !== 4'd0) begin bad++; $display("[TB] FAIL reset_step got %0d want 0", stepO); end
    total++; if (periodO !== PW'(300)) begin bad++; $display("[TB] FAIL reset_period got %0d want 300", periodO); end
    total++; if (powerO !== 10'd100) begin bad++; $display("[TB] FAIL reset_power got %0d want 100", powerO); end
    total++; if (dirO !== 1'b0) begin bad++; $display("[TB] FAIL reset_dir got %0d want 0", dirO); end
    total++; if (stepStbO !== 1'b0 || roundStbO !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes got %0d/%0d want 0/0", stepStbO, roundStbO); end
  endtask

  task automatic test_first_step;
    int n; bit ok;
    rstI = 1'b0;
    tick();
    total++; if (stateO !== 2'd1) begin bad++; $display("[TB] FAIL run_entry state got %0d want 1", stateO); end
    waitStep(n, ok);
    total++; if (!ok || n != 300) begin bad++; $display("[TB] FAIL first_step_delay got %0d want 300", n); end
    total++; if (stepO !== 4'd1 || roundStbO !== 1'b0) begin bad++; $display("[TB] FAIL first_step got step %0d round %0d want 1/0", stepO, roundStbO); end
    waitStep(n, ok);
    total++; if (!ok || n != 300) begin bad++; $display("[TB] FAIL second_step_delay got %0d want 300", n); end
    total++; if (stepO !== 4'd0 || roundStbO !== 1'b1) begin bad++; $display("[TB] FAIL wrap_step got step %0d round %0d want 0/1", stepO, roundStbO); end
  endtask

  task automatic test_speed_inc;
    bit ok; int expP; int d;
    speedIncI = 1'b1; powerIncI = 1'b1;
    runRounds(3, ok);
    total++; if (!ok || periodO !== PW'(300)) begin bad++; $display("[TB] FAIL inc_hold3 got %0d want 300", periodO); end
    runRounds(1, ok);
    total++; if (!ok || periodO !== PW'(282)) begin bad++; $display("[TB] FAIL inc_first got %0d want 282", periodO); end
    total++; if (powerO !== 10'd140) begin bad++; $display("[TB] FAIL power_inc4 got %0d want 140", powerO); end
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(265)) begin bad++; $display("[TB] FAIL inc_second got %0d want 265", periodO); end
    expP = 265;
    for (int i = 0; i < 60 && expP != PMIN; i++) begin
      runRounds(4, ok);
      d = expP >> 4;
      if (d == 0) d = 1;
      expP = expP - d;
      if (expP < PMIN) expP = PMIN;
      total++; if (!ok || periodO !== PW'(expP)) begin bad++; $display("[TB] FAIL inc_ramp got %0d want %0d", periodO, expP); end
    end
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(40)) begin bad++; $display("[TB] FAIL inc_floor got %0d want 40", periodO); end
    total++; if (powerO !== 10'd1000) begin bad++; $display("[TB] FAIL power_ceiling got %0d want 1000", powerO); end
    speedIncI = 1'b0; powerIncI = 1'b0;
  endtask

  task automatic test_speed_dec;
    bit ok;
    speedDecI = 1'b1; powerDecI = 1'b1;
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(40)) begin bad++; $display("[TB] FAIL dec_after_turn got %0d want 40", periodO); end
    runRounds(1, ok);
    total++; if (!ok || periodO !== PW'(42)) begin bad++; $display("[TB] FAIL dec_first got %0d want 42", periodO); end
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(44)) begin bad++; $display("[TB] FAIL dec_second got %0d want 44", periodO); end
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(46)) begin bad++; $display("[TB] FAIL dec_third got %0d want 46", periodO); end
    speedDecI = 1'b0;
  endtask

  task automatic test_alternate;
    bit ok;
    for (int r = 0; r < 8; r++) begin
      speedIncI = (r % 2 == 0);
      speedDecI = (r % 2 == 1);
      runRounds(1, ok);
      total++; if (!ok || periodO !== PW'(46)) begin bad++; $display("[TB] FAIL alternate round %0d got %0d want 46", r, periodO); end
    end
    speedIncI = 1'b0; speedDecI = 1'b0;
  endtask

  task automatic test_power;
    bit ok;
    total++; if (powerO !== 10'd790) begin bad++; $display("[TB] FAIL power_dec21 got %0d want 790", powerO); end
    runRounds(79, ok);
    total++; if (!ok || powerO !== 10'd0) begin bad++; $display("[TB] FAIL power_zero got %0d want 0", powerO); end
    runRounds(3, ok);
    total++; if (!ok || powerO !== 10'd0) begin bad++; $display("[TB] FAIL power_floor got %0d want 0", powerO); end
    powerDecI = 1'b0; powerIncI = 1'b1;
    runRounds(2, ok);
    total++; if (!ok || powerO !== 10'd20) begin bad++; $display("[TB] FAIL power_up2 got %0d want 20", powerO); end
    powerDecI = 1'b1;
    runRounds(3, ok);
    total++; if (!ok || powerO !== 10'd20) begin bad++; $display("[TB] FAIL power_both got %0d want 20", powerO); end
    powerIncI = 1'b0; powerDecI = 1'b0;
    total++; if (periodO !== PW'(46)) begin bad++; $display("[TB] FAIL power_period got %0d want 46", periodO); end
  endtask

  task automatic test_reverse_abort;
    bit ok;
    invRotateI = 1'b1;
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd2 || periodO !== PW'(46)) begin bad++; $display("[TB] FAIL abort_enter got state %0d period %0d want 2/46", stateO, periodO); end
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd2 || periodO !== PW'(48)) begin bad++; $display("[TB] FAIL abort_ramp got state %0d period %0d want 2/48", stateO, periodO); end
    invRotateI = 1'b0;
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd1 || dirO !== 1'b0 || periodO !== PW'(48)) begin bad++; $display("[TB] FAIL abort_return got state %0d dir %0d period %0d want 1/0/48", stateO, dirO, periodO); end
  endtask

  task automatic test_reverse;
    bit ok; int expP; int d; int n;
    invRotateI = 1'b1;
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd2 || periodO !== PW'(48)) begin bad++; $display("[TB] FAIL rev_enter got state %0d period %0d want 2/48", stateO, periodO); end
    expP = 48;
    for (int i = 0; i < 80 && expP != PMAX; i++) begin
      runRounds(1, ok);
      d = expP >> 4;
      if (d == 0) d = 1;
      expP = expP + d;
      if (expP > PMAX) expP = PMAX;
      total++; if (!ok || stateO !== 2'd2 || periodO !== PW'(expP)) begin bad++; $display("[TB] FAIL rev_ramp got state %0d period %0d want 2/%0d", stateO, periodO, expP); end
    end
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd1 || dirO !== 1'b1 || periodO !== PW'(300)) begin bad++; $display("[TB] FAIL rev_flip got state %0d dir %0d period %0d want 1/1/300", stateO, dirO, periodO); end
    total++; if (stepO !== 4'd0) begin bad++; $display("[TB] FAIL rev_flip_step got %0d want 0", stepO); end
    waitStep(n, ok);
    total++; if (!ok || n != 300 || stepO !== 4'd1 || roundStbO !== 1'b1) begin bad++; $display("[TB] FAIL rev_step_down got n %0d step %0d round %0d want 300/1/1", n, stepO, roundStbO); end
    waitStep(n, ok);
    total++; if (!ok || stepO !== 4'd0 || roundStbO !== 1'b0) begin bad++; $display("[TB] FAIL rev_step_next got step %0d round %0d want 0/0", stepO, roundStbO); end
  endtask

  task automatic test_dec_ceiling;
    bit ok;
    speedDecI = 1'b1;
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(300)) begin bad++; $display("[TB] FAIL dec_ceiling got %0d want 300", periodO); end
    speedDecI = 1'b0; speedIncI = 1'b1;
    runRounds(4, ok);
    total++; if (!ok || periodO !== PW'(300)) begin bad++; $display("[TB] FAIL inc_after_turn got %0d want 300", periodO); end
    runRounds(1, ok);
    total++; if (!ok || periodO !== PW'(282)) begin bad++; $display("[TB] FAIL inc_reverse_dir got %0d want 282", periodO); end
    speedIncI = 1'b0;
  endtask

  task automatic test_force_stop;
    int n; bit ok;
    repeat (50) tick();
    forceStopI = 1'b1;
    tick();
    total++; if (stateO !== 2'd0 || stepStbO !== 1'b0 || roundStbO !== 1'b0) begin bad++; $display("[TB] FAIL stop_state got state %0d strobes %0d/%0d want 0/0/0", stateO, stepStbO, roundStbO); end
    total++; if (periodO !== PW'(300) || stepO !== 4'd0) begin bad++; $display("[TB] FAIL stop_restore got period %0d step %0d want 300/0", periodO, stepO); end
    total++; if (powerO !== 10'd20) begin bad++; $display("[TB] FAIL stop_power got %0d want 20", powerO); end
    invRotateI = 1'b0;
    repeat (5) tick();
    total++; if (dirO !== 1'b0 || stepStbO !== 1'b0 || stateO !== 2'd0) begin bad++; $display("[TB] FAIL idle_hold got dir %0d stb %0d state %0d want 0/0/0", dirO, stepStbO, stateO); end
    forceStopI = 1'b0;
    tick();
    waitStep(n, ok);
    total++; if (!ok || n != 300 || stepO !== 4'd1) begin bad++; $display("[TB] FAIL restart_step got n %0d step %0d want 300/1", n, stepO); end
  endtask

  task automatic test_reset_mid_reverse;
    bit ok;
    invRotateI = 1'b1;
    runRounds(1, ok);
    total++; if (!ok || stateO !== 2'd2) begin bad++; $display("[TB] FAIL pre_reset_state got %0d want 2", stateO); end
    repeat (100) tick();
    rstI = 1'b1;
    tick();
    total++; if (stateO !== 2'd0 || stepStbO !== 1'b0 || roundStbO !== 1'b0) begin bad++; $display("[TB] FAIL rst_rev_state got state %0d strobes %0d/%0d want 0/0/0", stateO, stepStbO, roundStbO); end
    total++; if (periodO !== PW'(300) || powerO !== 10'd100) begin bad++; $display("[TB] FAIL rst_rev_values got period %0d power %0d want 300/100", periodO, powerO); end
    total++; if (stepO !== 4'd0 || dirO !== 1'b0) begin bad++; $display("[TB] FAIL rst_rev_step got step %0d dir %0d want 0/0", stepO, dirO); end
    rstI = 1'b0; startI = 1'b0; invRotateI = 1'b0;
    tick();
  endtask

  // Run every scenario in order and report the totals
  initial begin
    test_reset();
    test_first_step();
    test_speed_inc();
    test_speed_dec();
    test_alternate();
    test_power();
    test_reverse_abort();
    test_reverse();
    test_dec_ceiling();
    test_force_stop();
    test_reset_mid_reverse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
